// File: rtl/jk_excitation_driver.sv
// ---------------------------------------------------------------------------
// jk_excitation_driver
//
// Drive side of a WIDTH-bit bank of JK flip-flops that shares clk. Desired
// next-state vectors are queued in a small FIFO. Each target is served in
// three cycles:
//   IDLE  - pop the head, derive per-bit J/K from the bank's current Q and
//           the target, register them, and raise the bank clock enable.
//   DRIVE - flop_en is high for exactly this cycle; the bank updates on the
//           closing edge.
//   CHECK - compare the bank's new Q against the latched target. A
//           difference produces a one-cycle mismatch pulse and bumps a
//           saturating error counter.
//
// Parameters
//   WIDTH    bits in the driven JK bank / target vector width
//   DEPTH    target FIFO entries (power of 2, >= 2)
//   DC_FILL  don't-care J/K resolution: 0 = set/reset only, 1 = prefer toggle
//
// Ports
//   clk        in   1      clock, all state on posedge
//   rst_n      in   1      synchronous active-low reset
//   tgt_valid  in   1      target vector offered
//   tgt_data   in   WIDTH  desired next Q of the bank
//   tgt_ready  out  1      FIFO can accept (registered occupancy only)
//   q_in       in   WIDTH  current Q of the driven bank
//   j_out      out  WIDTH  J inputs to the bank (registered)
//   k_out      out  WIDTH  K inputs to the bank (registered)
//   flop_en    out  1      one-cycle clock enable to the bank (registered)
//   busy       out  1      FSM not IDLE, or FIFO not empty
//   mismatch   out  1      one-cycle pulse: bank state != target after update
//   err_cnt    out  8      saturating count of mismatches
// ---------------------------------------------------------------------------
module jk_excitation_driver #(
  parameter int WIDTH   = 4,
  parameter int DEPTH   = 4,
  parameter int DC_FILL = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tgt_valid,
  input  logic [WIDTH-1:0] tgt_data,
  output logic             tgt_ready,
  input  logic [WIDTH-1:0] q_in,
  output logic [WIDTH-1:0] j_out,
  output logic [WIDTH-1:0] k_out,
  output logic             flop_en,
  output logic             busy,
  output logic             mismatch,
  output logic [7:0]       err_cnt
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRIVE = 2'd1;
  localparam logic [1:0] ST_CHECK = 2'd2;

  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ZERO = '0;
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  // Per-bit excitation table. The don't-care entry takes the DC_FILL value:
  // with 0 the bank only ever sees set/reset/hold, with 1 every changing
  // bit is driven as a toggle and every holding bit keeps one input active.
  function automatic logic [2*WIDTH-1:0] excite(
    input logic [WIDTH-1:0] cur,
    input logic [WIDTH-1:0] nxt
  );
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic             dc;
    dc = (DC_FILL != 0);
    j  = '0;
    k  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      case ({cur[i], nxt[i]})
        2'b00:   begin j[i] = 1'b0; k[i] = dc;   end
        2'b01:   begin j[i] = 1'b1; k[i] = dc;   end
        2'b10:   begin j[i] = dc;   k[i] = 1'b1; end
        default: begin j[i] = dc;   k[i] = 1'b0; end
      endcase
    end
    return {j, k};
  endfunction

  // Error counter holds at all-ones instead of wrapping.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [1:0]       state;
  logic [WIDTH-1:0] fifo_mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic [WIDTH-1:0] head;
  logic [WIDTH-1:0] tgt_q;
  logic             full;
  logic             push;
  logic             pop;

  assign full      = (count == CNT_FULL);
  assign tgt_ready = ~full;
  assign push      = tgt_valid & ~full;
  assign pop       = (state == ST_IDLE) & (count != CNT_ZERO);
  assign head      = fifo_mem[rd_ptr];
  assign busy      = (state != ST_IDLE) | (count != CNT_ZERO);

  // ---- target FIFO: storage (data only, never reset) ----
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= tgt_data;
    end
  end

  // ---- target FIFO: pointers and occupancy ----
  // Pointers are AW bits wide, so wrap-around falls out of the arithmetic
  // for a power-of-two DEPTH.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // ---- issue: latch the popped target for the later check ----
  always_ff @(posedge clk) begin
    if (pop) begin
      tgt_q <= head;
    end
  end

  // ---- control FSM and registered bank outputs ----
  // j_out/k_out are reset because the bank sees them directly; outside an
  // issue they hold their last value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      j_out    <= '0;
      k_out    <= '0;
      flop_en  <= 1'b0;
      mismatch <= 1'b0;
      err_cnt  <= 8'd0;
    end else begin
      flop_en  <= 1'b0;
      mismatch <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pop) begin
            {j_out, k_out} <= excite(q_in, head);
            flop_en        <= 1'b1;
            state          <= ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          state <= ST_CHECK;
        end
        ST_CHECK: begin
          if (q_in != tgt_q) begin
            mismatch <= 1'b1;
            err_cnt  <= sat_inc(err_cnt);
          end
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jk_excitation_driver.sv
// Bench for jk_excitation_driver: two instances (DC_FILL=0 and DC_FILL=1),
// each driving a behavioural JK bank. Bank 0 can have bits forced to 0.
module tb_jk_excitation_driver;

  logic clk = 1'b0;
  logic rst_n;

  logic       tgt_valid0, tgt_ready0, flop_en0, busy0, mismatch0;
  logic [3:0] tgt_data0, q0, j0, k0;
  logic [7:0] err_cnt0;
  logic       load0;
  logic [3:0] loadval0, stuck0;

  logic       tgt_valid1, tgt_ready1, flop_en1, busy1, mismatch1;
  logic [3:0] tgt_data1, q1, j1, k1;
  logic [7:0] err_cnt1;
  logic       load1;
  logic [3:0] loadval1;

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0] log_jk [1024];
  int strb_n = 0;
  int mm_n   = 0;

  always #5 clk = ~clk;

  jk_excitation_driver #(.WIDTH(4), .DEPTH(4), .DC_FILL(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .tgt_valid(tgt_valid0), .tgt_data(tgt_data0),
    .tgt_ready(tgt_ready0), .q_in(q0), .j_out(j0), .k_out(k0),
    .flop_en(flop_en0), .busy(busy0), .mismatch(mismatch0), .err_cnt(err_cnt0)
  );

  jk_excitation_driver #(.WIDTH(4), .DEPTH(4), .DC_FILL(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .tgt_valid(tgt_valid1), .tgt_data(tgt_data1),
    .tgt_ready(tgt_ready1), .q_in(q1), .j_out(j1), .k_out(k1),
    .flop_en(flop_en1), .busy(busy1), .mismatch(mismatch1), .err_cnt(err_cnt1)
  );

  // Characteristic equation of a JK flop: 00 hold, 01 reset, 10 set, 11 toggle.
  function automatic logic [3:0] jk_next(input logic [3:0] q, input logic [3:0] j,
                                         input logic [3:0] k);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) begin
      case ({j[i], k[i]})
        2'b00:   r[i] = q[i];
        2'b01:   r[i] = 1'b0;
        2'b10:   r[i] = 1'b1;
        default: r[i] = ~q[i];
      endcase
    end
    return r;
  endfunction

  always @(posedge clk) begin
    if (load0)         q0 <= loadval0;
    else if (flop_en0) q0 <= jk_next(q0, j0, k0) & ~stuck0;
    if (load1)         q1 <= loadval1;
    else if (flop_en1) q1 <= jk_next(q1, j1, k1);
  end

  // Record every strobe of bank 0 and count mismatch pulses.
  always @(negedge clk) begin
    if (flop_en0 === 1'b1) begin
      if (strb_n < 1024) log_jk[strb_n] <= {j0, k0};
      strb_n <= strb_n + 1;
    end
    if (mismatch0 === 1'b1) mm_n <= mm_n + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Called just after a negedge; returns just after the negedge that follows
  // the accepting posedge.
  task automatic push0(input logic [3:0] d);
    int t;
    t = 0;
    tgt_valid0 = 1'b1;
    tgt_data0  = d;
    while (tgt_ready0 !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (tgt_ready0 !== 1'b1) chk("push_timeout", 32'd0, 32'd1);
    @(negedge clk);
    tgt_valid0 = 1'b0;
  endtask

  task automatic wait_idle0(input int limit);
    int t;
    t = 0;
    while (busy0 !== 1'b0 && t < limit) begin
      @(negedge clk);
      t++;
    end
    if (busy0 !== 1'b0) chk("idle_timeout", 32'd0, 32'd1);
    @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  logic [3:0] v4   [6] = '{4'b0011, 4'b1100, 4'b1111, 4'b0000, 4'b1001, 4'b0110};
  logic [7:0] exp4 [7] = '{8'h5A, 8'h24, 8'hC3, 8'h30, 8'h0F, 8'h90, 8'h69};
  logic [3:0] v6   [4] = '{4'b0011, 4'b0101, 4'b1001, 4'b1110};

  initial begin
    int base, mbase, t, stall_idx, seen;

    // 1: reset held 2 cycles with valid asserted
    rst_n = 1'b0;
    tgt_valid0 = 1'b1; tgt_data0 = 4'b1111;
    tgt_valid1 = 1'b0; tgt_data1 = 4'b0000;
    load0 = 1'b1; loadval0 = 4'b0000; stuck0 = 4'b0000;
    load1 = 1'b1; loadval1 = 4'b1100;
    @(negedge clk);
    @(negedge clk);
    chk("rst_ready",    tgt_ready0, 1);
    chk("rst_err_cnt",  err_cnt0,   0);
    chk("rst_flop_en",  flop_en0,   0);
    chk("rst_busy",     busy0,      0);
    chk("rst_j",        j0,         0);
    chk("rst_k",        k0,         0);
    chk("rst_mismatch", mismatch0,  0);
    rst_n = 1'b1;
    tgt_valid0 = 1'b0;
    load0 = 1'b0; load1 = 1'b0;
    @(negedge clk);
    chk("rst_no_push_busy", busy0,   0);
    chk("rst_no_push_q",    q0,      4'b0000);
    chk("rst_no_strobe",    flop_en0, 0);

    // 2: DC_FILL=0, q=0000 -> 1010
    push0(4'b1010);
    chk("t2_latency_en", flop_en0, 0);
    chk("t2_busy",       busy0,    1);
    @(negedge clk);
    chk("t2_flop_en", flop_en0, 1);
    chk("t2_j",       j0,       4'b1010);
    chk("t2_k",       k0,       4'b0000);
    @(negedge clk);
    chk("t2_flop_en_off", flop_en0, 0);
    chk("t2_q",           q0,       4'b1010);
    chk("t2_j_hold",      j0,       4'b1010);
    @(negedge clk);
    chk("t2_mismatch", mismatch0, 0);
    chk("t2_idle",     busy0,     0);

    // 3: DC_FILL=1, q=1100 -> 1010
    tgt_valid1 = 1'b1; tgt_data1 = 4'b1010;
    @(negedge clk);
    tgt_valid1 = 1'b0;
    @(negedge clk);
    chk("t3_flop_en", flop_en1, 1);
    chk("t3_j",       j1,       4'b1110);
    chk("t3_k",       k1,       4'b0111);
    @(negedge clk);
    chk("t3_q",           q1,       4'b1010);
    chk("t3_flop_en_off", flop_en1, 0);
    @(negedge clk);
    chk("t3_mismatch", mismatch1, 0);
    chk("t3_err_cnt",  err_cnt1,  0);

    // 4: six back-to-back pushes while the driver is in DRIVE
    base = strb_n;
    push0(4'b0101);
    t = 0;
    while (flop_en0 !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("t4_first_strobe", flop_en0, 1);
    stall_idx = -1;
    for (int i = 0; i < 6; i++) begin
      tgt_valid0 = 1'b1;
      tgt_data0  = v4[i];
      t = 0;
      while (tgt_ready0 !== 1'b1 && t < 50) begin
        if (stall_idx < 0) stall_idx = i;
        @(negedge clk);
        t++;
      end
      @(negedge clk);
    end
    tgt_valid0 = 1'b0;
    chk("t4_stall_index", stall_idx, 5);
    wait_idle0(200);
    chk("t4_strobes", strb_n - base, 7);
    for (int i = 0; i < 7; i++) chk($sformatf("t4_jk%0d", i), log_jk[base + i], exp4[i]);
    chk("t4_final_q",  q0,       4'b0110);
    chk("t4_err_cnt",  err_cnt0, 0);

    // 5: bit0 stuck at 0
    stuck0 = 4'b0001;
    mbase = mm_n;
    for (int i = 0; i < 3; i++) push0(4'b0001);
    wait_idle0(100);
    chk("t5_err_cnt3",   err_cnt0,     3);
    chk("t5_pulses3",    mm_n - mbase, 3);
    chk("t5_stuck_q",    q0,           4'b0000);
    for (int i = 0; i < 300; i++) push0(4'b0001);
    wait_idle0(2000);
    chk("t5_err_sat",    err_cnt0,     255);
    chk("t5_pulses303",  mm_n - mbase, 303);
    stuck0 = 4'b0000;

    // 6: reset during DRIVE with two targets queued
    base = strb_n;
    seen = 0;
    tgt_valid0 = 1'b1;
    tgt_data0  = v6[0];
    for (int i = 1; i < 20 && seen < 2; i++) begin
      @(negedge clk);
      if (flop_en0 === 1'b1) seen++;
      if (i < 4) tgt_data0 = v6[i];
      else       tgt_valid0 = 1'b0;
    end
    tgt_valid0 = 1'b0;
    chk("t6_reached_drive", seen, 2);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t6_flop_en", flop_en0,   0);
    chk("t6_busy",    busy0,      0);
    chk("t6_ready",   tgt_ready0, 1);
    chk("t6_err_cnt", err_cnt0,   0);
    chk("t6_j",       j0,         0);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("t6_no_more_strobes", strb_n - base, 2);
    chk("t6_still_idle",      busy0,         0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
